// File: rtl/pf_pkg.sv
// Shared colours, score-flash states and default
// playfield geometry for the renderer.
package pf_pkg;

  localparam logic [5:0] COL_WHITE  = 6'b111111;
  localparam logic [5:0] COL_BLACK  = 6'b000000;
  localparam logic [5:0] COL_GRAY   = 6'b101010;
  localparam logic [5:0] COL_GREEN  = 6'b001100;
  localparam logic [5:0] COL_RED    = 6'b110000;
  localparam logic [5:0] COL_YELLOW = 6'b111100;
  localparam logic [5:0] COL_BLUE   = 6'b000011;
  localparam logic [5:0] COL_ORANGE = 6'b110100;

  typedef enum logic [1:0] {
    S_WHITE,
    S_GAIN,
    S_LOSS
  } score_state_t;

  localparam int DEF_N_LANES     = 4;
  localparam int DEF_LANE_X0     = 220;
  localparam int DEF_LANE_W      = 35;
  localparam int DEF_LANE_GAP    = 20;
  localparam int DEF_HIT_ROW0    = 435;
  localparam int DEF_HIT_H       = 10;
  localparam int DEF_HIT_FRAMES  = 6;
  localparam int DEF_SCORE_FRAMES = 10;
  localparam int DEF_SCORE_W     = 17;

  function automatic logic [5:0] score_rgb(
    score_state_t s
  );
    logic [5:0] c;
    c = COL_WHITE;
    unique case (s)
      S_GAIN:  c = COL_GREEN;
      S_LOSS:  c = COL_RED;
      default: c = COL_WHITE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lane_flash_timer.sv
// Per-lane hit-zone flash: a press reloads the frame
// counter; frame ticks count it down after release.
module lane_flash_timer #(
  parameter int FRAMES = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic press,
  input  logic frame_tick,
  output logic flash
);

  localparam int CW = $clog2(FRAMES + 1);
  localparam logic [CW-1:0] LOAD = CW'(FRAMES);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  // press reload beats the frame-tick countdown
  always_comb begin
    cnt_d = cnt;
    if (press) begin
      cnt_d = LOAD;
    end else if (frame_tick && cnt != '0) begin
      cnt_d = cnt - 1'b1;
    end
  end

  // counter and registered flash state
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      flash <= 1'b0;
    end else begin
      cnt   <= cnt_d;
      flash <= press | (cnt_d != '0);
    end
  end

endmodule

// File: rtl/playfield_renderer.sv
// Playfield compositor: lanes, hit zone, borders and
// text into one registered 6-bit RGB pixel stream.
module playfield_renderer
  import pf_pkg::*;
#(
  parameter int N_LANES            = DEF_N_LANES,
  parameter int LANE_X0            = DEF_LANE_X0,
  parameter int LANE_W             = DEF_LANE_W,
  parameter int LANE_GAP           = DEF_LANE_GAP,
  parameter int HIT_ROW0           = DEF_HIT_ROW0,
  parameter int HIT_H              = DEF_HIT_H,
  parameter int HIT_FLASH_FRAMES   = DEF_HIT_FRAMES,
  parameter int SCORE_FLASH_FRAMES = DEF_SCORE_FRAMES,
  parameter int SCORE_W            = DEF_SCORE_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             col,
  input  logic [9:0]             row,
  input  logic                   valid,
  input  logic                   frame_tick,
  input  logic [6*N_LANES-1:0]   lane_rgb,
  input  logic [6*N_LANES-1:0]   lane_color,
  input  logic [N_LANES-1:0]     lane_btn_n,
  input  logic                   strum_n,
  input  logic [SCORE_W-1:0]     score,
  input  logic                   text_active,
  input  logic [5:0]             text_rgb,
  output logic [5:0]             rgb,
  output logic                   rgb_valid,
  output logic [5:0]             score_color,
  output logic [N_LANES-1:0]     lane_flash
);

  localparam int STRIDE   = LANE_W + LANE_GAP;
  localparam int LANE_END =
    LANE_X0 + (N_LANES - 1) * STRIDE + LANE_W;

  localparam logic [11:0] B_COL1 = 12'd1;
  localparam logic [11:0] B_COLR = 12'd639;
  localparam logic [11:0] B_LEFT = 12'(LANE_X0 - 10);
  localparam logic [11:0] B_RGHT = 12'(LANE_END + 10);
  localparam logic [11:0] HR_LO  = 12'(HIT_ROW0);
  localparam logic [11:0] HR_HI  = 12'(HIT_ROW0 + HIT_H);

  localparam int SCW = $clog2(SCORE_FLASH_FRAMES + 1);
  localparam logic [SCW-1:0] SLOAD =
    SCW'(SCORE_FLASH_FRAMES);
  localparam logic [SCW-1:0] SONE = SCW'(1);

  logic [11:0] cx;
  logic [11:0] ry;
  logic [N_LANES-1:0] in_lane;
  logic [N_LANES-1:0] press;
  logic hit_row;
  logic border;
  logic [5:0] lane_px;
  logic [5:0] hit_px;
  logic [5:0] pix;

  score_state_t state;
  score_state_t state_d;
  logic [SCW-1:0] scnt;
  logic [SCW-1:0] scnt_d;
  logic [SCORE_W-1:0] prev_score;

  assign cx = {2'b00, col};
  assign ry = {2'b00, row};

  genvar g;
  generate
    for (g = 0; g < N_LANES; g++) begin : g_lane
      localparam logic [11:0] LB =
        12'(LANE_X0 + g * STRIDE);
      localparam logic [11:0] LE =
        12'(LANE_X0 + g * STRIDE + LANE_W);

      assign in_lane[g] = (cx > LB) && (cx < LE);
      assign press[g] = ~lane_btn_n[g] & ~strum_n;

      lane_flash_timer #(
        .FRAMES(HIT_FLASH_FRAMES)
      ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .press     (press[g]),
        .frame_tick(frame_tick),
        .flash     (lane_flash[g])
      );
    end
  endgenerate

  assign hit_row = (ry >= HR_LO) && (ry < HR_HI);
  assign border  = (cx == B_COL1) || (cx == B_COLR) ||
                   (cx == B_LEFT) || (cx == B_RGHT);

  // pick the lane under the beam (lanes are disjoint)
  always_comb begin
    lane_px = COL_BLACK;
    hit_px  = COL_BLACK;
    for (int i = 0; i < N_LANES; i++) begin
      if (in_lane[i]) begin
        lane_px = lane_rgb[6*i +: 6];
        hit_px  = lane_flash[i] ?
                  lane_color[6*i +: 6] : COL_GRAY;
      end
    end
  end

  // layer priority: border, hit zone, text, lane
  always_comb begin
    pix = COL_BLACK;
    if (!valid) begin
      pix = COL_BLACK;
    end else if (border) begin
      pix = COL_WHITE;
    end else if (hit_row) begin
      pix = hit_px;
    end else if (text_active) begin
      pix = text_rgb;
    end else if (|in_lane) begin
      pix = lane_px;
    end
  end

  // one-cycle registered output stage
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb       <= COL_BLACK;
      rgb_valid <= 1'b0;
    end else begin
      rgb       <= pix;
      rgb_valid <= valid;
    end
  end

  // score flash next state: any change reloads
  always_comb begin
    state_d = state;
    scnt_d  = scnt;
    if (score > prev_score) begin
      state_d = S_GAIN;
      scnt_d  = SLOAD;
    end else if (score < prev_score) begin
      state_d = S_LOSS;
      scnt_d  = SLOAD;
    end else if (state != S_WHITE && frame_tick) begin
      if (scnt == SONE) begin
        state_d = S_WHITE;
        scnt_d  = '0;
      end else begin
        scnt_d = scnt - 1'b1;
      end
    end
  end

  // score flash state, counter and previous score
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_WHITE;
      scnt       <= '0;
      prev_score <= '0;
    end else begin
      state      <= state_d;
      scnt       <= scnt_d;
      prev_score <= score;
    end
  end

  assign score_color = score_rgb(state);

endmodule
